pal_line_sequencer: RTL and testbench

- Controller for the Dragon PAL line-pulse path. It stretches the VDG's 262-line field to PAL length by holding the VDG clock for a number of padding lines after field sync falls and after it rises.
- While the VDG is held, it generates the synthetic 3 us line-sync pulses itself. Otherwise it passes the VDG's horizontal sync straight through.
- It also maintains a field toggle and an output line count for downstream PAL logic.

---
 rtl/pal_seq_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/pal_line_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pal_line_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_seq_pkg.sv
// Shared types and default timing for the Dragon PAL line-pulse sequencer.
package pal_seq_pkg;

  typedef enum logic [1:0] {
    PASS,
    PAD_A,
    VSYNC,
    PAD_B
  } state_t;

  localparam int unsigned DEF_LINE_CLKS   = 228;
  localparam int unsigned DEF_PULSE_CLKS  = 11;
  localparam int unsigned DEF_PAD_A_LINES = 25;
  localparam int unsigned DEF_PAD_B_LINES = 25;

  localparam int unsigned LINE_CNT_W = 9;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a trailing edge-detect flop; all flops reset high
// so an idle-high sync line produces no strobe out of reset.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pal_line_sequencer.sv
// Stretches the VDG field to PAL length by holding the VDG clock for padding
// lines around field sync and synthesising line-sync pulses while it is held.
module pal_line_sequencer
  import pal_seq_pkg::*;
#(
  parameter int unsigned LINE_CLKS   = DEF_LINE_CLKS,
  parameter int unsigned PULSE_CLKS  = DEF_PULSE_CLKS,
  parameter int unsigned PAD_A_LINES = DEF_PAD_A_LINES,
  parameter int unsigned PAD_B_LINES = DEF_PAD_B_LINES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  hs_n,
  input  logic                  fs_n,
  output logic                  hold,
  output logic                  hs_out,
  output logic                  pad_active,
  output logic                  field,
  output logic [LINE_CNT_W-1:0] line_cnt
);

  localparam int unsigned TW      = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
  localparam int unsigned PAD_MAX = (PAD_A_LINES > PAD_B_LINES) ? PAD_A_LINES : PAD_B_LINES;
  localparam int unsigned PW      = $clog2(PAD_MAX) + 1;

  localparam logic [TW-1:0] T_LAST  = TW'(LINE_CLKS - 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CLKS);
  localparam logic [PW-1:0] N_A     = PW'(PAD_A_LINES);
  localparam logic [PW-1:0] N_B     = PW'(PAD_B_LINES);

  logic hs_sync, hs_fall;
  logic fs_sync, fs_rise, fs_fall;

  sync_edge_detect u_hs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (hs_n),
    .sync  (hs_sync),
    .rise  (),
    .fall  (hs_fall)
  );

  sync_edge_detect u_fs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fs_n),
    .sync  (fs_sync),
    .rise  (fs_rise),
    .fall  (fs_fall)
  );

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic [PW-1:0]         padcnt, padcnt_n;
  logic                  pending, pending_n;
  logic                  hold_n, hs_out_n, pad_act_n, field_n;
  logic [LINE_CNT_W-1:0] line_cnt_n;

  logic [LINE_CNT_W-1:0] lc_inc;
  logic [PW-1:0]         pad_inc, pad_lines;
  logic                  go_pad, leave;
  state_t                pad_tgt;

  assign lc_inc    = (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;
  assign pad_inc   = padcnt + 1'b1;
  assign pad_lines = (state == PAD_A) ? N_A : N_B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PASS;
      timer      <= '0;
      padcnt     <= '0;
      pending    <= 1'b0;
      hold       <= 1'b0;
      hs_out     <= 1'b1;
      pad_active <= 1'b0;
      field      <= 1'b0;
      line_cnt   <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      padcnt     <= padcnt_n;
      pending    <= pending_n;
      hold       <= hold_n;
      hs_out     <= hs_out_n;
      pad_active <= pad_act_n;
      field      <= field_n;
      line_cnt   <= line_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    padcnt_n   = padcnt;
    pending_n  = pending;
    hold_n     = hold;
    hs_out_n   = hs_out;
    pad_act_n  = pad_active;
    field_n    = field;
    line_cnt_n = line_cnt;
    go_pad     = 1'b0;
    leave      = 1'b0;
    pad_tgt    = PAD_A;

    case (state)
      PASS, VSYNC: begin
        hs_out_n = hs_sync;
        if (hs_fall) line_cnt_n = lc_inc;
        // A coincident HS fall is overridden by the FS fall clearing the count.
        if (fs_fall) begin
          field_n    = ~field;
          line_cnt_n = '0;
          pending_n  = 1'b0;
          if (!enable) begin
            state_n = PASS;
          end else if (PAD_A_LINES > 0) begin
            go_pad  = 1'b1;
            pad_tgt = PAD_A;
          end else begin
            state_n = VSYNC;
          end
        end else if (state == VSYNC && (fs_rise || pending)) begin
          pending_n = 1'b0;
          if (enable && PAD_B_LINES > 0) begin
            go_pad  = 1'b1;
            pad_tgt = PAD_B;
          end else begin
            state_n = PASS;
          end
        end
      end

      PAD_A, PAD_B: begin
        if (timer == '0) line_cnt_n = lc_inc;
        if (state == PAD_A && fs_rise) pending_n = 1'b1;
        if (timer == T_LAST) begin
          timer_n  = '0;
          hs_out_n = (T_PULSE != '0);
          hs_out_n = ~hs_out_n;
          if (!enable) begin
            leave   = 1'b1;
            state_n = PASS;
          end else if (pad_inc == pad_lines) begin
            // An FS rise already seen during PAD_A skips VSYNC entirely.
            if (state == PAD_B) begin
              leave   = 1'b1;
              state_n = PASS;
            end else if (pending || fs_rise) begin
              if (PAD_B_LINES > 0) begin
                go_pad  = 1'b1;
                pad_tgt = PAD_B;
              end else begin
                leave   = 1'b1;
                state_n = PASS;
              end
            end else begin
              leave   = 1'b1;
              state_n = VSYNC;
            end
          end else begin
            padcnt_n = pad_inc;
          end
        end else begin
          timer_n  = timer + 1'b1;
          hs_out_n = (timer_n >= T_PULSE);
        end
      end

      default: state_n = PASS;
    endcase

    if (leave) begin
      hold_n    = 1'b0;
      pad_act_n = 1'b0;
      hs_out_n  = hs_sync;
      padcnt_n  = '0;
      pending_n = 1'b0;
    end

    if (go_pad) begin
      state_n   = pad_tgt;
      timer_n   = '0;
      padcnt_n  = '0;
      pending_n = 1'b0;
      hold_n    = 1'b1;
      pad_act_n = 1'b1;
      hs_out_n  = (T_PULSE == '0);
    end
  end

endmodule

// File: tb/tb_pal_line_sequencer.sv
// Self-checking bench: field-level vector table, directed corner sequences and
// random stimulus, all compared cycle by cycle against a behavioural model.
module tb_pal_line_sequencer;

  localparam int L  = 20;
  localparam int P  = 4;
  localparam int PA = 3;
  localparam int PB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       hs_n = 1'b1;
  logic       fs_n = 1'b1;
  logic       hold, hs_out, pad_active, field;
  logic [8:0] line_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pal_line_sequencer #(
    .LINE_CLKS   (L),
    .PULSE_CLKS  (P),
    .PAD_A_LINES (PA),
    .PAD_B_LINES (PB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .hs_n       (hs_n),
    .fs_n       (fs_n),
    .hold       (hold),
    .hs_out     (hs_out),
    .pad_active (pad_active),
    .field      (field),
    .line_cnt   (line_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: inputs seen through a 3-deep sample history; a pad is
  // described by its kind and the number of clocks elapsed since it started.
  bit m_h1, m_h2, m_h3, m_f1, m_f2, m_f3;
  int m_kind;      // 0 none, 1 first pad, 2 second pad
  bit m_vsync;
  bit m_pend;
  int m_el;
  bit m_hold, m_hs, m_field;
  int m_lc;

  task automatic model_reset();
    {m_h1, m_h2, m_h3, m_f1, m_f2, m_f3} = '1;
    m_kind = 0; m_vsync = 0; m_pend = 0; m_el = 0;
    m_hold = 0; m_hs = 1; m_field = 0; m_lc = 0;
  endtask

  task automatic start_pad(input int kind);
    m_kind = kind; m_el = 0; m_vsync = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit hs_s, fs_s, hf, ff, fr;
    int pos, line;
    hs_s = m_h2;
    fs_s = m_f2;
    hf = m_h3 & ~m_h2;
    ff = m_f3 & ~m_f2;
    fr = ~m_f3 & m_f2;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = hs_n;
    m_f3 = m_f2; m_f2 = m_f1; m_f1 = fs_n;
    if (m_kind != 0) begin
      pos  = m_el % L;
      line = m_el / L;
      if (pos == 0 && m_lc < 511) m_lc++;
      if (m_kind == 1 && fr) m_pend = 1;
      m_el++;
      if (pos == L - 1) begin
        if (!enable) begin
          m_kind = 0; m_pend = 0;
        end else if (line + 1 == ((m_kind == 1) ? PA : PB)) begin
          if (m_kind == 2) m_kind = 0;
          else if (m_pend && PB > 0) start_pad(2);
          else if (m_pend) begin m_kind = 0; m_pend = 0; end
          else begin m_kind = 0; m_vsync = 1; end
        end
      end
      m_hs = (m_kind != 0) ? ((m_el % L) >= P) : hs_s;
    end else begin
      m_hs = hs_s;
      if (hf && m_lc < 511) m_lc++;
      if (ff) begin
        m_field = ~m_field; m_lc = 0; m_pend = 0;
        if (enable) begin
          start_pad(1);
          m_hs = 0;
        end else m_vsync = 0;
      end else if (m_vsync && (fr || m_pend)) begin
        m_pend = 0; m_vsync = 0;
        if (enable) begin
          start_pad(2);
          m_hs = 0;
        end
      end
    end
    m_hold = (m_kind != 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [12:0] a, e;
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    a = {hold, hs_out, pad_active, field, line_cnt};
    e = {m_hold, m_hs, m_hold, m_field, 9'(m_lc)};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model {hold,hs,pad,field,lc}: got %h expected %h at %0t", a, e, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; hs_n = 1; fs_n = 1; enable = 0;
    model_reset();
    repeat (2) tick();
    rst_n = 1;
  endtask

  typedef struct {
    bit en;
    bit fs;
    int hs_pulses;
    int exp_hold;
    int exp_lows;
    int exp_lc;
    int exp_field;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hc, lows, rises;
    bit prev_hold;

    vecs[0] = '{1'b1, 1'b0, 0, 60, 12, 3, 1};
    vecs[1] = '{1'b1, 1'b1, 0, 60, 12, 6, 1};
    vecs[2] = '{1'b0, 1'b0, 5, 0, 20, 5, 0};
    vecs[3] = '{1'b0, 1'b1, 0, 0, 0, 5, 0};
    vecs[4] = '{1'b1, 1'b0, 0, 60, 12, 3, 1};
    vecs[5] = '{1'b1, 1'b1, 0, 60, 12, 6, 1};

    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_state", {hold, hs_out, pad_active, field, line_cnt}, 13'h0800);

    for (int i = 0; i < 6; i++) begin
      hc = 0; lows = 0;
      enable = vecs[i].en;
      fs_n   = vecs[i].fs;
      for (int c = 0; c < 150; c++) begin
        if (c >= 5 && c < 5 + 10 * vecs[i].hs_pulses) hs_n = ((c - 5) % 10) >= 4;
        else hs_n = 1;
        tick();
        hc += int'(hold);
        lows += int'(!hs_out);
      end
      chk($sformatf("vec%0d_hold_clks", i), hc, vecs[i].exp_hold);
      chk($sformatf("vec%0d_hs_low_clks", i), lows, vecs[i].exp_lows);
      chk($sformatf("vec%0d_line_cnt", i), int'(line_cnt), vecs[i].exp_lc);
      chk($sformatf("vec%0d_field", i), int'(field), vecs[i].exp_field);
    end

    // Reset asserted in the middle of the first pad.
    do_reset();
    enable = 1; fs_n = 0;
    repeat (30) tick();
    chk("pre_reset_hold", int'(hold), 1);
    rst_n = 0;
    #1;
    chk("reset_mid_pad", {hold, hs_out, pad_active, field, line_cnt}, 13'h0800);
    model_reset();
    fs_n = 1;
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1;
    hc = 0;
    repeat (60) begin tick(); hc += int'(hold); end
    chk("post_reset_idle_hold", hc, 0);

    // FS rises during the first pad: both pads run back to back.
    do_reset();
    enable = 1; fs_n = 0;
    hc = 0; rises = 0; prev_hold = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 20) fs_n = 1;
      tick();
      hc += int'(hold);
      if (hold && !prev_hold) rises++;
      prev_hold = hold;
    end
    chk("merged_hold_clks", hc, 120);
    chk("merged_hold_rises", rises, 1);
    chk("merged_line_cnt", int'(line_cnt), 6);

    // Enable dropped at timer 7 of the second pad line with an FS rise pending.
    do_reset();
    enable = 1; fs_n = 0;
    repeat (3) tick();
    chk("drop_hold_start", int'(hold), 1);
    repeat (10) tick();
    fs_n = 1;
    repeat (17) tick();
    enable = 0;
    hc = 0;
    repeat (100) begin tick(); hc += int'(hold); end
    chk("drop_remaining_hold", hc, 12);
    chk("drop_line_cnt", int'(line_cnt), 2);
    chk("drop_pad_active", int'(pad_active), 0);

    // Line count saturation.
    do_reset();
    enable = 0;
    repeat (520) begin
      hs_n = 0; repeat (2) tick();
      hs_n = 1; repeat (2) tick();
    end
    repeat (5) tick();
    chk("sat_line_cnt", int'(line_cnt), 511);
    fs_n = 0;
    repeat (5) tick();
    chk("sat_clear_line_cnt", int'(line_cnt), 0);
    chk("sat_field", int'(field), 1);

    // Random stimulus against the model.
    do_reset();
    enable = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) hs_n = ~hs_n;
      if ($urandom_range(149) == 0) fs_n = ~fs_n;
      if ($urandom_range(399) == 0) enable = ~enable;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
